// File: rtl/mofn_pkg.sv
// -----------------------------------------------------------------------------
// mofn_pkg
// Shared definitions for the M-of-N stream checker:
//   - default parameter values (code width, weight, counter width, burst length)
//   - state_e : alarm state machine encoding
// -----------------------------------------------------------------------------
package mofn_pkg;

    localparam int DEF_N     = 5;
    localparam int DEF_M     = 2;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_BURST = 3;

    // OK      : no recent illegal words
    // SUSPECT : a run of illegal words is building up towards alarm
    // ALARM   : alarm raised, waiting for legal words
    // RECOVER : a run of legal words is building up towards OK
    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_ALARM   = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

endpackage

// File: rtl/mofn_popcount.sv
// -----------------------------------------------------------------------------
// mofn_popcount
// Purely combinational population count of an N-bit vector.
// Ports:
//   i_vec    [N-1:0]            : vector to count
//   o_weight [$clog2(N+1)-1:0]  : number of ones in i_vec (full range, no wrap)
// -----------------------------------------------------------------------------
module mofn_popcount
    import mofn_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]             i_vec,
    output logic [$clog2(N+1)-1:0]   o_weight
);

    localparam int W_W = $clog2(N+1);

    logic [W_W-1:0] w_sum;

    // Ripple sum of all bits; W_W is wide enough to hold N without wrapping.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = w_sum + W_W'(i_vec[i]);
        end
    end

    assign o_weight = w_sum;

endmodule

// File: rtl/mofn_stream_checker.sv
// -----------------------------------------------------------------------------
// mofn_stream_checker
// Checks a valid/ready stream of N-bit code words for constant weight M,
// returns a per-word verdict on a one-deep output register, counts illegal
// words with saturation and runs a burst-filtered alarm state machine.
// Ports:
//   CLK       : clock, rising edge
//   RST       : synchronous active-high reset
//   IN_VALID  : CODE valid this cycle
//   CODE      : code word under test (N bits)
//   IN_READY  : word accepted this cycle when IN_VALID is high
//   OUT_VALID : DET holds a result
//   OUT_READY : consumer takes the result this cycle
//   DET       : 0 = weight equals M, 1 = illegal word
//   CLR_CNT   : clears ERR_CNT and returns the state machine to OK
//   ERR_CNT   : saturating count of accepted illegal words (CNT_W bits)
//   ALARM     : high while in ALARM or RECOVER
// -----------------------------------------------------------------------------
module mofn_stream_checker
    import mofn_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int M     = DEF_M,
    parameter int CNT_W = DEF_CNT_W,
    parameter int BURST = DEF_BURST
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    input  logic [N-1:0]      CODE,
    output logic              IN_READY,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              DET,
    input  logic              CLR_CNT,
    output logic [CNT_W-1:0]  ERR_CNT,
    output logic              ALARM
);

    localparam int W_W   = $clog2(N+1);
    localparam int RUN_W = $clog2(BURST+1);

    localparam logic [W_W-1:0]   WEIGHT_OK = W_W'(M);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(BURST);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [W_W-1:0]   w_weight;
    logic             w_illegal;
    logic             w_accept;

    logic             r_out_valid;
    logic             r_det;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_alarm;

    state_e           r_state;
    logic [RUN_W-1:0] r_run;
    state_e           w_state_base;
    logic [RUN_W-1:0] w_run_base;
    logic [RUN_W-1:0] w_run_inc;
    state_e           w_state_nxt;
    logic [RUN_W-1:0] w_run_nxt;

    mofn_popcount #(
        .N (N)
    ) u_popcount (
        .i_vec    (CODE),
        .o_weight (w_weight)
    );

    assign w_illegal = (w_weight != WEIGHT_OK);

    // One-deep output slot: a new word may enter when the slot is empty or
    // is being drained in the same cycle.
    assign IN_READY = !r_out_valid || OUT_READY;
    assign w_accept = IN_VALID && IN_READY;

    // Output slot: load verdict on accept, drop it once taken, hold otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_det       <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_det       <= w_illegal;
        end else if (OUT_READY) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating illegal-word counter; a clear coinciding with an illegal
    // accept still records that word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err_cnt <= '0;
        end else if (CLR_CNT) begin
            r_err_cnt <= (w_accept && w_illegal) ? CNT_ONE : '0;
        end else if (w_accept && w_illegal && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + CNT_ONE;
        end
    end

    // State, run counter and registered alarm flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_OK;
            r_run   <= '0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_alarm <= (w_state_nxt == ST_ALARM) || (w_state_nxt == ST_RECOVER);
        end
    end

    // A clear rewinds to OK first, so a word accepted on the same edge is
    // judged from OK.
    assign w_state_base = CLR_CNT ? ST_OK : r_state;
    assign w_run_base   = CLR_CNT ? '0 : r_run;
    assign w_run_inc    = w_run_base + RUN_ONE;

    // Next-state logic; only accepted words move the machine.
    always_comb begin
        w_state_nxt = w_state_base;
        w_run_nxt   = w_run_base;
        if (w_accept) begin
            case (w_state_base)
                ST_OK: begin
                    if (w_illegal) begin
                        if (RUN_ONE == RUN_LAST) begin
                            w_state_nxt = ST_ALARM;
                            w_run_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_SUSPECT;
                            w_run_nxt   = RUN_ONE;
                        end
                    end else begin
                        w_state_nxt = ST_OK;
                        w_run_nxt   = '0;
                    end
                end
                ST_SUSPECT: begin
                    if (w_illegal) begin
                        if (w_run_inc == RUN_LAST) begin
                            w_state_nxt = ST_ALARM;
                            w_run_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_SUSPECT;
                            w_run_nxt   = w_run_inc;
                        end
                    end else begin
                        w_state_nxt = ST_OK;
                        w_run_nxt   = '0;
                    end
                end
                ST_ALARM: begin
                    if (!w_illegal) begin
                        if (RUN_ONE == RUN_LAST) begin
                            w_state_nxt = ST_OK;
                            w_run_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_RECOVER;
                            w_run_nxt   = RUN_ONE;
                        end
                    end else begin
                        w_state_nxt = ST_ALARM;
                        w_run_nxt   = '0;
                    end
                end
                ST_RECOVER: begin
                    if (!w_illegal) begin
                        if (w_run_inc == RUN_LAST) begin
                            w_state_nxt = ST_OK;
                            w_run_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_RECOVER;
                            w_run_nxt   = w_run_inc;
                        end
                    end else begin
                        w_state_nxt = ST_ALARM;
                        w_run_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_OK;
                    w_run_nxt   = '0;
                end
            endcase
        end else begin
            w_state_nxt = w_state_base;
            w_run_nxt   = w_run_base;
        end
    end

    assign OUT_VALID = r_out_valid;
    assign DET       = r_det;
    assign ERR_CNT   = r_err_cnt;
    assign ALARM     = r_alarm;

endmodule

// File: tb/tb_mofn_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_mofn_stream_checker
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model that tracks alarm mode plus the length of the current
// streak of words pulling away from that mode.
// -----------------------------------------------------------------------------
module tb_mofn_stream_checker;

    localparam int N       = 5;
    localparam int M       = 2;
    localparam int CNT_W   = 2;
    localparam int BURST   = 3;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    localparam logic [N-1:0] ILL  = 5'b11111;
    localparam logic [N-1:0] LEG  = 5'b00011;
    localparam logic [N-1:0] ILL3 = 5'b00111;

    logic             CLK = 1'b0;
    logic             RST;
    logic             IN_VALID;
    logic [N-1:0]     CODE;
    logic             IN_READY;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             DET;
    logic             CLR_CNT;
    logic [CNT_W-1:0] ERR_CNT;
    logic             ALARM;

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model
    bit m_valid  = 1'b0;
    bit m_det    = 1'b0;
    bit m_alarm  = 1'b0;
    int m_cnt    = 0;
    int m_streak = 0;

    mofn_stream_checker #(
        .N     (N),
        .M     (M),
        .CNT_W (CNT_W),
        .BURST (BURST)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .CODE      (CODE),
        .IN_READY  (IN_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .DET       (DET),
        .CLR_CNT   (CLR_CNT),
        .ERR_CNT   (ERR_CNT),
        .ALARM     (ALARM)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge.
    task automatic model_edge(input bit rst, input bit iv, input logic [N-1:0] code,
                              input bit ordy, input bit clr);
        bit acc;
        bit ill;
        if (rst) begin
            m_valid  = 1'b0;
            m_det    = 1'b0;
            m_alarm  = 1'b0;
            m_cnt    = 0;
            m_streak = 0;
        end else begin
            acc = iv && (!m_valid || ordy);
            ill = ($countones(code) != M);
            if (acc) begin
                m_valid = 1'b1;
                m_det   = ill;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            if (clr) begin
                m_cnt    = (acc && ill) ? 1 : 0;
                m_alarm  = 1'b0;
                m_streak = 0;
            end else if (acc && ill && m_cnt < CNT_SAT) begin
                m_cnt = m_cnt + 1;
            end
            if (acc) begin
                // a word that pushes away from the current mode extends the
                // streak; BURST such words in a row flip the mode
                if (ill != m_alarm) begin
                    m_streak = m_streak + 1;
                    if (m_streak == BURST) begin
                        m_alarm  = !m_alarm;
                        m_streak = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
        end
    endtask

    // One cycle: drive at negedge, check IN_READY, clock, check outputs.
    task automatic step(input bit rst, input bit iv, input logic [N-1:0] code,
                        input bit ordy, input bit clr);
        RST       = rst;
        IN_VALID  = iv;
        CODE      = code;
        OUT_READY = ordy;
        CLR_CNT   = clr;
        #1;
        if (!rst) check("in_ready", IN_READY, !m_valid || ordy);
        model_edge(rst, iv, code, ordy, clr);
        @(posedge CLK);
        #1;
        check("out_valid", OUT_VALID, m_valid);
        check("det", DET, m_det);
        check("err_cnt", ERR_CNT, m_cnt);
        check("alarm", ALARM, m_alarm);
        @(negedge CLK);
    endtask

    function automatic logic [N-1:0] rand_code();
        logic [N-1:0] c;
        if ($urandom_range(1, 0) == 0) begin
            c = '0;
            while ($countones(c) < M) c[$urandom_range(N-1, 0)] = 1'b1;
        end else begin
            c = N'($urandom);
        end
        return c;
    endfunction

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; CODE = '0; OUT_READY = 1'b0; CLR_CNT = 1'b0;
        @(negedge CLK);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, ILL, 1'b1, 1'b0);
        check("rst_out_valid", OUT_VALID, 1'b0);
        check("rst_err_cnt", ERR_CNT, 0);
        check("rst_alarm", ALARM, 1'b0);

        // legal then illegal word, back-to-back
        step(1'b0, 1'b1, LEG, 1'b1, 1'b0);
        check("seq1_det_legal", DET, 1'b0);
        step(1'b0, 1'b1, ILL3, 1'b1, 1'b0);
        check("seq1_det_illegal", DET, 1'b1);
        check("seq1_err_cnt", ERR_CNT, 1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // backpressure: one accept, then stalled for two more cycles
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, ILL, 1'b0, 1'b0);
        check("bp_err_cnt", ERR_CNT, 1);
        check("bp_det_held", DET, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // three illegal words raise alarm
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, ILL, 1'b1, 1'b0);
        check("burst_alarm_on", ALARM, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        // a legal word in the middle breaks the run
        step(1'b0, 1'b1, ILL, 1'b1, 1'b0);
        step(1'b0, 1'b1, ILL, 1'b1, 1'b0);
        step(1'b0, 1'b1, LEG, 1'b1, 1'b0);
        step(1'b0, 1'b1, ILL, 1'b1, 1'b0);
        step(1'b0, 1'b1, ILL, 1'b1, 1'b0);
        check("broken_run_alarm", ALARM, 1'b0);

        // recovery from alarm
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, ILL, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, LEG, 1'b1, 1'b0);
        check("recover_alarm_off", ALARM, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, ILL, 1'b1, 1'b0);
        step(1'b0, 1'b1, LEG, 1'b1, 1'b0);
        step(1'b0, 1'b1, LEG, 1'b1, 1'b0);
        step(1'b0, 1'b1, ILL, 1'b1, 1'b0);
        check("recover_abort_alarm", ALARM, 1'b1);

        // counter saturation and clear-with-accept
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, ILL, 1'b1, 1'b0);
        check("cnt_saturated", ERR_CNT, 3);
        step(1'b0, 1'b1, ILL, 1'b1, 1'b1);
        check("clr_with_accept", ERR_CNT, 1);

        // reset while holding a result in alarm
        step(1'b0, 1'b1, ILL, 1'b1, 1'b0);
        step(1'b0, 1'b1, ILL, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("pre_rst_valid", OUT_VALID, 1'b1);
        check("pre_rst_alarm", ALARM, 1'b1);
        step(1'b1, 1'b1, ILL, 1'b0, 1'b0);
        check("post_rst_valid", OUT_VALID, 1'b0);
        check("post_rst_alarm", ALARM, 1'b0);
        check("post_rst_cnt", ERR_CNT, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99, 0) == 0,
                 $urandom_range(3, 0) != 0,
                 rand_code(),
                 $urandom_range(3, 0) != 0,
                 $urandom_range(29, 0) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
